// File: rtl/data_island_packet_assembler.sv
// Data island packet assembler: serialises a 24-bit header and four 56-bit subpackets plus BCH ECC
// into 32 nine-bit slots. Optional output pipeline register: DATA_ISLAND_OUTPUT_REG_EN.
module data_island_packet_assembler (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [8:0]       packet_data,
    output logic [4:0]       counter,
    output logic             packet_loaded
);

    localparam logic [7:0] BchPoly = 8'h83;

    // One LSB-first step of the 1+x^6+x^7+x^8 BCH code.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic d);
        logic f;
        f = ecc[0] ^ d;
        return (ecc >> 1) ^ (f ? BchPoly : 8'h00);
    endfunction

    logic [4:0]       cnt_q;
    logic [23:0]      cur_header;
    logic [3:0][55:0] cur_sub;
    logic [7:0]       ecc_h;
    logic [3:0][7:0]  ecc_s;

    logic slot_last;
    logic load_packet;
    logic hdr_phase;
    logic sub_phase;

    assign slot_last   = data_island_period && (cnt_q == 5'd31);
    assign load_packet = !data_island_period || slot_last;
    assign hdr_phase   = cnt_q < 5'd24;
    assign sub_phase   = cnt_q < 5'd28;

    logic [31:0]      hdr_ext;
    logic [3:0][63:0] sub_ext;
    logic [5:0]       even_idx;
    logic [5:0]       odd_idx;
    logic [2:0]       ecc_h_idx;
    logic [2:0]       ecc_s_even;
    logic [2:0]       ecc_s_odd;
    logic             hdr_bit;
    logic [3:0]       even_bits;
    logic [3:0]       odd_bits;
    logic [7:0]       ecc_h_next;
    logic [3:0][7:0]  ecc_s_next;
    logic [8:0]       slot_data;
    logic [4:0]       slot_counter;

    // Zero-extended copies keep every slot index in range; only the in-range part is ever selected.
    always_comb begin
        hdr_ext    = {8'h00, cur_header};
        even_idx   = {cnt_q, 1'b0};
        odd_idx    = {cnt_q, 1'b1};
        ecc_h_idx  = cnt_q[2:0];
        ecc_s_even = {cnt_q[1:0], 1'b0};
        ecc_s_odd  = {cnt_q[1:0], 1'b1};
        hdr_bit    = hdr_phase ? hdr_ext[cnt_q] : ecc_h[ecc_h_idx];
        ecc_h_next = bch_step(ecc_h, hdr_ext[cnt_q]);
        sub_ext    = '0;
        even_bits  = '0;
        odd_bits   = '0;
        ecc_s_next = '0;
        for (int i = 0; i < 4; i++) begin
            sub_ext[i]    = {8'h00, cur_sub[i]};
            even_bits[i]  = sub_phase ? sub_ext[i][even_idx] : ecc_s[i][ecc_s_even];
            odd_bits[i]   = sub_phase ? sub_ext[i][odd_idx] : ecc_s[i][ecc_s_odd];
            ecc_s_next[i] = bch_step(bch_step(ecc_s[i], sub_ext[i][even_idx]),
                                     sub_ext[i][odd_idx]);
        end
        slot_data    = data_island_period ? {odd_bits, even_bits, hdr_bit} : 9'd0;
        slot_counter = data_island_period ? cnt_q : 5'd0;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cnt_q      <= 5'd0;
            cur_header <= '0;
            cur_sub    <= '0;
            ecc_h      <= '0;
            ecc_s      <= '0;
        end else begin
            cnt_q <= data_island_period ? cnt_q + 5'd1 : 5'd0;
            if (load_packet) begin
                cur_header <= header;
                cur_sub    <= sub;
                ecc_h      <= '0;
                ecc_s      <= '0;
            end else begin
                // ECC freezes once its final value is on the wire.
                if (hdr_phase) ecc_h <= ecc_h_next;
                if (sub_phase) ecc_s <= ecc_s_next;
            end
        end
    end

    assign packet_loaded = slot_last;

`ifdef DATA_ISLAND_OUTPUT_REG_EN
    logic [8:0] packet_data_q;
    logic [4:0] counter_q;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            packet_data_q <= 9'd0;
            counter_q     <= 5'd0;
        end else begin
            packet_data_q <= slot_data;
            counter_q     <= slot_counter;
        end
    end

    assign packet_data = packet_data_q;
    assign counter     = counter_q;
`else
    assign packet_data = slot_data;
    assign counter     = slot_counter;
`endif

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// Table-driven bench for data_island_packet_assembler with a from-scratch serial ECC model and
// hand-written reset-abandon sequence.
module tb_data_island_packet_assembler;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             data_island_period;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [8:0]       packet_data;
    logic [4:0]       counter;
    logic             packet_loaded;

    data_island_packet_assembler dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .packet_data        (packet_data),
        .counter            (counter),
        .packet_loaded      (packet_loaded)
    );

    always #5 clk_pixel = ~clk_pixel;

`ifdef DATA_ISLAND_OUTPUT_REG_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 0;
`endif

    typedef struct {
        logic             dip;
        logic [23:0]      hdr;
        logic [3:0][55:0] sub;
        logic [8:0]       pd;
        logic [4:0]       cnt;
        logic             ld;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] act_pd[$];
    int         total = 0;
    int         bad   = 0;

    // Reference model state: slot counter and latched packet.
    int               mk = 0;
    logic [23:0]      mh = '0;
    logic [3:0][55:0] ms = '0;

    function automatic logic [7:0] serial_ecc(input logic [55:0] bits, input int n);
        logic [7:0] e;
        logic       f;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            f = e[0] ^ bits[i];
            e = (e >> 1) ^ (f ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    function automatic logic [8:0] pd_of(input logic [23:0] h, input logic [3:0][55:0] s,
                                         input int k);
        logic [8:0]      p;
        logic [7:0]      eh;
        logic [3:0][7:0] es;
        eh = serial_ecc({32'd0, h}, 24);
        for (int i = 0; i < 4; i++) es[i] = serial_ecc(s[i], 56);
        p[0] = (k < 24) ? h[k] : eh[k - 24];
        for (int i = 0; i < 4; i++) begin
            p[1 + i] = (2 * k < 56) ? s[i][2 * k] : es[i][2 * k - 56];
            p[5 + i] = (2 * k + 1 < 56) ? s[i][2 * k + 1] : es[i][2 * k - 55];
        end
        return p;
    endfunction

    task automatic add(input logic d, input logic [23:0] h, input logic [3:0][55:0] s);
        vec_t v;
        v.dip = d;
        v.hdr = h;
        v.sub = s;
        v.pd  = d ? pd_of(mh, ms, mk) : 9'd0;
        v.cnt = d ? 5'(mk) : 5'd0;
        v.ld  = d && (mk == 31);
        if (!d || mk == 31) begin
            mh = h;
            ms = s;
        end
        mk = d ? (mk + 1) % 32 : 0;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0d: got %h want %h", nm, n, act, exp);
        end
    endtask

    logic [3:0][55:0] z, s0, s1, s2, s3;
    logic [23:0]      h1, h2, h3;
    logic [8:0]       prev_pd;
    logic [4:0]       prev_cnt;
    logic [8:0]       e_pd;
    logic [4:0]       e_cnt;
    logic [7:0]       hb;

    initial begin
        z  = '0;
        s0 = '0;
        s0[0] = 56'h1;
        s1 = '0;
        s1[0] = 56'h0123456789ABCD;
        s1[2] = 56'hF0F0F0F0F0F0F0;
        s2 = '0;
        s2[1] = 56'h13579BDF02468A;
        s2[3] = 56'h80000000000001;
        s3 = '0;
        s3[0] = 56'h00000000000081;
        s3[1] = 56'hA5A5A5A5A5A5A5;
        s3[3] = 56'hFEDCBA98765432;
        h1 = 24'h123456;
        h2 = 24'hABCDEF;
        h3 = 24'h00C3A5;

        // Idle after reset, header=1 loaded for the first island.
        for (int i = 0; i < 4; i++) add(1'b0, 24'h000001, z);
        for (int k = 0; k < 32; k++) add(1'b1, (k == 31) ? 24'h0 : 24'h000001, z);
        for (int c = 0; c < 64; c++) add(1'b1, 24'h0, (c == 63) ? s0 : z);
        for (int k = 0; k < 32; k++) add(1'b1, 24'h0, (k == 31) ? z : s0);
        for (int i = 0; i < 2; i++) add(1'b0, h1, s1);
        for (int k = 0; k < 10; k++) add(1'b1, h1, s1);
        for (int i = 0; i < 3; i++) add(1'b0, h2, s2);
        for (int k = 0; k < 32; k++) add(1'b1, (k == 31) ? 24'h0 : h2, (k == 31) ? z : s2);
        for (int i = 0; i < 3; i++) add(1'b0, 24'h0, z);

        reset = 1'b1;
        data_island_period = 1'b0;
        header = '0;
        sub = '0;
        repeat (2) @(posedge clk_pixel);
        @(negedge clk_pixel);
        chk("rst_pd", 0, 32'(packet_data), 32'd0);
        chk("rst_cnt", 0, 32'(counter), 32'd0);
        chk("rst_ld", 0, 32'(packet_loaded), 32'd0);
        @(posedge clk_pixel);
        #1 reset = 1'b0;

        prev_pd  = 9'd0;
        prev_cnt = 5'd0;
        foreach (vecs[n]) begin
            data_island_period = vecs[n].dip;
            header = vecs[n].hdr;
            sub = vecs[n].sub;
            @(negedge clk_pixel);
`ifdef DATA_ISLAND_OUTPUT_REG_EN
            e_pd     = prev_pd;
            e_cnt    = prev_cnt;
            prev_pd  = vecs[n].pd;
            prev_cnt = vecs[n].cnt;
`else
            e_pd  = vecs[n].pd;
            e_cnt = vecs[n].cnt;
`endif
            chk("vec_pd", n, 32'(packet_data), 32'(e_pd));
            chk("vec_cnt", n, 32'(counter), 32'(e_cnt));
            chk("vec_ld", n, 32'(packet_loaded), 32'(vecs[n].ld));
            act_pd.push_back(packet_data);
            @(posedge clk_pixel);
            #1;
        end

        // Header ECC of 24'h000001, hand-computed, on bit 0 of slots 24..31 of the first island.
        for (int b = 0; b < 8; b++) hb[b] = act_pd[4 + 24 + b + Lat][0];
        chk("hdr_ecc_4a", 0, 32'(hb), 32'h4A);

        // Abandon a packet with asynchronous reset, then restart cleanly.
        header = h3;
        sub = s3;
        data_island_period = 1'b0;
        @(posedge clk_pixel);
        #1 data_island_period = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_pixel);
            chk("pre_rst_cnt", c, 32'(counter), (c >= Lat) ? 32'(c - Lat) : 32'd0);
            chk("pre_rst_pd", c, 32'(packet_data),
                (c >= Lat) ? 32'(pd_of(h3, s3, c - Lat)) : 32'd0);
            if (c < 5) begin
                @(posedge clk_pixel);
                #1;
            end
        end
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pd", 0, 32'(packet_data), 32'd0);
        chk("async_rst_cnt", 0, 32'(counter), 32'd0);
        chk("async_rst_ld", 0, 32'(packet_loaded), 32'd0);
        @(posedge clk_pixel);
        #1 reset = 1'b0;
        data_island_period = 1'b0;
        @(posedge clk_pixel);
        #1 data_island_period = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_pixel);
            chk("post_rst_cnt", c, 32'(counter), (c >= Lat) ? 32'(c - Lat) : 32'd0);
            chk("post_rst_pd", c, 32'(packet_data),
                (c >= Lat) ? 32'(pd_of(h3, s3, c - Lat)) : 32'd0);
            @(posedge clk_pixel);
            #1;
        end
        data_island_period = 1'b0;
        repeat (2) @(posedge clk_pixel);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_island_packet_assembler.md
DATA_ISLAND_PACKET_ASSEMBLER -- requirements
Module: data_island_packet_assembler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 `clk_pixel`  in  1  TMDS/pixel clock; all state on its rising edge.
REQ-003 `reset`  in  1  asynchronous, active-high reset.
REQ-004 `data_island_period`  in  1  high while the encoder is in a data island period; packet slots of 32 cycles.
REQ-005 `header`  in  24  packet header HB2:HB1:HB0, HB0 in bits [7:0].
REQ-006 `sub`  in  4x56  subpackets 0..3, byte 0 in bits [7:0].
REQ-007 `packet_data`  out  9  per-cycle island payload to the TERC4 channel mapper.
REQ-008 `counter`  out  5  bit slot 0..31 within the current packet.
REQ-009 `packet_loaded`  out  1  one-cycle pulse: the next packet was captured; upstream may advance.

Function
REQ-010 Internal copies `cur_header`/`cur_sub` SHALL load from `header`/`sub` every cycle that `data_island_period`=0, and on the cycle with `data_island_period`=1 and `counter`=31.
REQ-011 `packet_loaded` SHALL be 1 only when `data_island_period`=1 and `counter`=31.
REQ-012 `counter` SHALL increment each cycle while `data_island_period`=1, wrapping 31->0, and SHALL be 0 while `data_island_period`=0.
REQ-013 Slot k (k=`counter`) SHALL produce the following `packet_data` fields:
- bit 0 = `cur_header[k]` for k<24, else `ecc_h[k-24]`.
- bits [4:1] = bit 2k of subpackets 3..0 (sub0 in bit 1).
- bits [8:5] = bit 2k+1 of subpackets 3..0 (sub0 in bit 5).
- Subpacket bit j≥56 SHALL be taken from `ecc_s[j-56]` of that subpacket.
REQ-014 ECC SHALL be BCH with generator 1+x^6+x^7+x^8.
- Serial step per data bit d: `f` = `ecc[0]`^d; `ecc` = (`ecc`>>1) ^ (`f` ? 8'h83 : 0).
- Bits SHALL be consumed LSB-first, in transmit order.
REQ-015 ECC update timing:
- `ecc_h` SHALL take one step per cycle for k<24.
- Each `ecc_s` SHALL take two steps per cycle (bit 2k, then 2k+1) for k<28.
- All ECC registers SHALL hold otherwise.
- Final ECC SHALL be valid when first transmitted (k=24 header, k=28 subpackets) without combinational lookahead.
REQ-016 All ECC registers SHALL clear to 0 when `counter`=31 and whenever `data_island_period`=0.
REQ-017 Deassertion of `data_island_period` mid-packet SHALL abandon the packet:
- `counter` SHALL go to 0 and ECC SHALL clear next cycle.
- No `packet_loaded` SHALL be issued.
- Re-assertion SHALL start a fresh packet at k=0.
REQ-018 With `data_island_period`=0, `packet_data` SHALL be 9'd0.
REQ-019 Output latency from `counter` to `packet_data` SHALL be 0 cycles (combinational), unless REQ-024 applies.

Reset
REQ-020 `reset` SHALL asynchronously clear `counter`, all ECC registers, `cur_header`, `cur_sub` and `packet_loaded` to 0.
REQ-021 After reset, `packet_data`=0, `counter`=0 and `packet_loaded`=0.
REQ-022 Reset asserted mid-packet SHALL abandon the packet as in REQ-017.
REQ-023 The first island after reset release SHALL start at k=0.

Configuration
REQ-024 Macro `DATA_ISLAND_OUTPUT_REG_EN` controls an output pipeline register.
- Defined: `packet_data` and `counter` SHALL be registered, giving 1-cycle latency from internal slot to output. The registers SHALL reset to 0, and `packet_loaded` SHALL remain unregistered.
- Undefined: behaviour SHALL be as in REQ-019.

Verification
REQ-025 Reset released, `data_island_period`=0 -> `packet_data`=0, `counter`=0, `packet_loaded`=0 every cycle.
REQ-026 Island of 32 cycles with `header`=24'h000001, `sub`=all 0:
- `packet_data[0]` = 1 at k=0, 0 at k=1..23.
- k=24..31 carry ECC 8'h4A LSB-first (0,1,0,1,0,0,1,0).
- `packet_data[8:1]`=0 throughout.
REQ-027 All-zero packet for 64 consecutive island cycles -> `packet_data`=0 throughout; `packet_loaded` pulses at cycles 31 and 63 only.
REQ-028 `sub[0]`=56'h1 only:
- `packet_data[1]`=1 at k=0.
- Subpacket-0 ECC bytes 8'h4A-equivalent checked against the serial model, on bits 1/5 at k=28..31.
- Other subpacket lanes 0.
REQ-029 `data_island_period` dropped at k=10 and re-raised 3 cycles later with a new header -> `counter` restarts at 0, new header bit 0 appears at k=0, and ECC matches a fresh computation.
REQ-030 With `DATA_ISLAND_OUTPUT_REG_EN` defined, repeat REQ-026 -> identical sequence delayed by exactly one cycle; async `reset` mid-packet -> outputs 0 immediately.
